// File: rtl/dw_pkg.sv
// Shared types for the depthwise window register array and its upstream sequencer.
package dw_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_PAD   = 2'b01,
    CMD_REUSE = 2'b10,
    CMD_RSVD  = 2'b11
  } dw_cmd_e;

  localparam int PIX_DW = 8;
  typedef logic [PIX_DW-1:0] pixel_t;

endpackage

// File: rtl/dw_reg_array_reuse_fifo.sv
// Show-ahead reuse FIFO for one lane boundary; an extra pointer MSB tells full from empty.
module reuse_fifo #(
  parameter int DW     = 8,
  parameter int FDEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(FDEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [FDEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop from a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dw_reg_array.sv
// POY x KSIZE sliding window for the depthwise MAC array; vertical overlap rows
// are recirculated through per-lane reuse FIFOs instead of being refetched.
module dw_reg_array
  import dw_pkg::*;
#(
  parameter int DW     = 8,
  parameter int KSIZE  = 3,
  parameter int POY    = 3,
  parameter int FDEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd,
  input  logic [POY*DW-1:0]         buf_pix,
  output logic [POY*KSIZE*DW-1:0]   win_data,
  output logic                      win_valid,
  output logic                      col_stb,
  output logic                      err_ovf,
  output logic                      err_udf,
  output logic                      err_cmd
);

  localparam int CW = $clog2(KSIZE + 1);
  localparam logic [CW-1:0] KS_C    = CW'(KSIZE);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [DW-1:0] r         [POY][KSIZE];
  logic [DW-1:0] new_col   [POY];
  logic [DW-1:0] fifo_head [POY-1];
  logic [POY-2:0] fifo_full;
  logic [POY-2:0] fifo_empty;
  logic [CW-1:0]  fill_cnt;
  logic [CW-1:0]  fill_nxt;

  dw_cmd_e cmd_e;
  logic    accept;
  logic    shift;
  logic    fifo_push;
  logic    fifo_pop;

  assign cmd_e     = dw_cmd_e'(cmd);
  // clear has priority: a command arriving with it is dropped entirely.
  assign accept    = cmd_valid && !clear;
  assign shift     = accept && (cmd_e != CMD_RSVD);
  assign fifo_push = accept && ((cmd_e == CMD_LOAD) || (cmd_e == CMD_REUSE));
  assign fifo_pop  = accept && (cmd_e == CMD_REUSE);

  assign fill_nxt  = (fill_cnt == KS_C) ? fill_cnt : fill_cnt + CNT_ONE;
  assign win_valid = (fill_cnt == KS_C);

  always_comb begin
    for (int p = 0; p < POY; p++) begin
      new_col[p] = '0;
      case (cmd_e)
        CMD_LOAD:  new_col[p] = buf_pix[p*DW +: DW];
        CMD_REUSE: new_col[p] = (p == POY-1) ? buf_pix[p*DW +: DW] : fifo_head[p];
        default:   new_col[p] = '0;
      endcase
    end
  end

  // FIFO g carries the pixels entering lane g+1 back to lane g on a later row.
  for (genvar g = 0; g < POY-1; g++) begin : g_fifo
    reuse_fifo #(
      .DW     (DW),
      .FDEPTH (FDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (new_col[g+1]),
      .dout  (fifo_head[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < POY; p++)
        for (int k = 0; k < KSIZE; k++)
          r[p][k] <= '0;
      fill_cnt <= '0;
      col_stb  <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
      err_cmd  <= 1'b0;
    end else begin
      col_stb <= 1'b0;
      if (clear) begin
        for (int p = 0; p < POY; p++)
          for (int k = 0; k < KSIZE; k++)
            r[p][k] <= '0;
        fill_cnt <= '0;
      end else if (shift) begin
        for (int p = 0; p < POY; p++) begin
          for (int k = KSIZE-1; k > 0; k--)
            r[p][k] <= r[p][k-1];
          r[p][0] <= new_col[p];
        end
        fill_cnt <= fill_nxt;
        col_stb  <= (fill_nxt == KS_C);
      end
      if (fifo_push && !fifo_pop && (|fifo_full)) err_ovf <= 1'b1;
      if (fifo_pop && (|fifo_empty))               err_udf <= 1'b1;
      if (accept && (cmd_e == CMD_RSVD))           err_cmd <= 1'b1;
    end
  end

  always_comb begin
    win_data = '0;
    for (int p = 0; p < POY; p++)
      for (int k = 0; k < KSIZE; k++)
        win_data[(p*KSIZE+k)*DW +: DW] = r[p][k];
  end

endmodule

// File: tb/tb_dw_reg_array.sv
// Directed bench for dw_reg_array: each command pushes its hand-derived window into a
// queue; a negedge monitor pops and compares one expectation per cycle.
module tb_dw_reg_array;
  import dw_pkg::*;

  localparam int DW = 8, KSIZE = 3, POY = 3, FDEPTH = 32;
  localparam int WW = POY*KSIZE*DW;
  localparam int EW = WW + 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd = 2'b00;
  logic [POY*DW-1:0] buf_pix = '0;
  logic [WW-1:0]     win_data;
  logic              win_valid, col_stb, err_ovf, err_udf, err_cmd;

  always #5 clk = ~clk;

  dw_reg_array #(.DW(DW), .KSIZE(KSIZE), .POY(POY), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cmd_valid(cmd_valid), .cmd(cmd),
    .buf_pix(buf_pix), .win_data(win_data), .win_valid(win_valid), .col_stb(col_stb),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_cmd(err_cmd)
  );

  // Expected-state model: columns are supplied explicitly by each directed vector.
  logic [DW-1:0] m_r [POY][KSIZE];
  int            m_fill = 0;
  logic          m_stb = 1'b0;
  logic          exp_ovf = 1'b0, exp_udf = 1'b0, exp_cmd = 1'b0;
  logic [EW-1:0] exp_q [$];
  string         name_q [$];
  int            checks = 0;
  int            failures = 0;

  task automatic step(input logic rst_v, input logic clr_v, input logic vld_v,
                      input logic [1:0] c,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] n0, input logic [7:0] n1, input logic [7:0] n2,
                      input string nm);
    logic [EW-1:0] e;
    logic [7:0]    ncol [POY];
    @(negedge clk);
    #1;
    rst_n = rst_v; clear = clr_v; cmd_valid = vld_v; cmd = c; buf_pix = {b2, b1, b0};
    @(posedge clk);
    ncol[0] = n0; ncol[1] = n1; ncol[2] = n2;
    m_stb = 1'b0;
    if (!rst_v || clr_v) begin
      for (int p = 0; p < POY; p++)
        for (int k = 0; k < KSIZE; k++)
          m_r[p][k] = '0;
      m_fill = 0;
      if (!rst_v) begin
        exp_ovf = 1'b0; exp_udf = 1'b0; exp_cmd = 1'b0;
      end
    end else if (vld_v && c == 2'b11) begin
      exp_cmd = 1'b1;
    end else if (vld_v) begin
      for (int p = 0; p < POY; p++) begin
        for (int k = KSIZE-1; k > 0; k--) m_r[p][k] = m_r[p][k-1];
        m_r[p][0] = ncol[p];
      end
      if (m_fill < KSIZE) m_fill++;
      m_stb = (m_fill == KSIZE);
    end
    e = '0;
    for (int p = 0; p < POY; p++)
      for (int k = 0; k < KSIZE; k++)
        e[(p*KSIZE+k)*DW +: DW] = m_r[p][k];
    e[WW +: 5] = {(m_fill == KSIZE), m_stb, exp_ovf, exp_udf, exp_cmd};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  logic [EW-1:0] mon_e;
  string         mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks += 4;
      if (win_data !== mon_e[WW-1:0]) begin
        failures++;
        $display("FAIL %s.win_data got=%h exp=%h", mon_nm, win_data, mon_e[WW-1:0]);
      end
      if (win_valid !== mon_e[WW+4]) begin
        failures++;
        $display("FAIL %s.win_valid got=%b exp=%b", mon_nm, win_valid, mon_e[WW+4]);
      end
      if (col_stb !== mon_e[WW+3]) begin
        failures++;
        $display("FAIL %s.col_stb got=%b exp=%b", mon_nm, col_stb, mon_e[WW+3]);
      end
      if ({err_ovf, err_udf, err_cmd} !== mon_e[WW +: 3]) begin
        failures++;
        $display("FAIL %s.err got=%b exp=%b", mon_nm, {err_ovf, err_udf, err_cmd}, mon_e[WW +: 3]);
      end
    end
  end

  initial begin
    // Reset, with a LOAD held on the inputs that must be ignored.
    step(0, 0, 1, CMD_LOAD, 99, 99, 99, 0, 0, 0, "rst_a");
    step(0, 0, 1, CMD_LOAD, 99, 99, 99, 0, 0, 0, "rst_b");

    // Fill: FIFO0 ends holding 20,21,22 and FIFO1 30,31,32.
    step(1, 0, 1, CMD_LOAD, 10, 20, 30, 10, 20, 30, "fill0");
    step(1, 0, 1, CMD_LOAD, 11, 21, 31, 11, 21, 31, "fill1");
    step(1, 0, 1, CMD_LOAD, 12, 22, 32, 12, 22, 32, "fill2");

    // Reuse: lanes 0-1 ignore buf_pix and take FIFO heads.
    step(1, 0, 1, CMD_REUSE, 8'hEE, 8'hEE, 40, 20, 30, 40, "reuse0");
    step(1, 0, 1, CMD_REUSE, 8'hEE, 8'hEE, 41, 21, 31, 41, "reuse1");

    step(1, 0, 1, CMD_PAD, 5, 6, 7, 0, 0, 0, "pad");

    // Underflow on empty FIFOs; the sticky flag survives the next clear.
    step(1, 1, 0, CMD_LOAD, 0, 0, 0, 0, 0, 0, "clear0");
    exp_udf = 1'b1;
    step(1, 0, 1, CMD_REUSE, 8'hEE, 8'hEE, 77, 0, 0, 77, "reuse_udf");
    step(1, 1, 0, CMD_LOAD, 0, 0, 0, 0, 0, 0, "clear1");

    // 33 LOADs: the last push finds both FIFOs full and is dropped.
    for (int i = 0; i < 33; i++) begin
      if (i == 32) exp_ovf = 1'b1;
      step(1, 0, 1, CMD_LOAD, 8'(i), 8'(100+i), 8'(200+i),
           8'(i), 8'(100+i), 8'(200+i), $sformatf("ovf_load%0d", i));
    end

    // 32 REUSEs on full FIFOs return the first 32 pushes in order.
    for (int j = 0; j < 32; j++)
      step(1, 0, 1, CMD_REUSE, 8'hEE, 8'hEE, 8'(50+j),
           8'(100+j), 8'(200+j), 8'(50+j), $sformatf("wrap_reuse%0d", j));
    // After the pointers wrap, heads are the pixels pushed during those REUSEs.
    step(1, 0, 1, CMD_REUSE, 8'hEE, 8'hEE, 90, 200, 50, 90, "wrap_head");

    // clear beats a simultaneous LOAD: fill restarts from zero.
    step(1, 1, 1, CMD_LOAD, 1, 2, 3, 0, 0, 0, "clear_load");
    step(1, 0, 1, CMD_LOAD, 4, 5, 6, 4, 5, 6, "post_clr0");
    step(1, 0, 1, CMD_LOAD, 7, 8, 9, 7, 8, 9, "post_clr1");
    step(1, 0, 1, 2'b11, 60, 61, 62, 0, 0, 0, "rsvd");
    step(1, 0, 1, CMD_LOAD, 1, 2, 3, 1, 2, 3, "post_rsvd");
    step(1, 0, 0, CMD_LOAD, 0, 0, 0, 0, 0, 0, "idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dw_reg_array.md
# dw_reg_array

Depthwise-convolution window register array. It sits directly downstream of the input-buffer address sequencer. It consumes that sequencer's 2-bit array command and the per-lane pixels returned by the input buffer. It holds a POY × KSIZE sliding window and, through per-lane reuse FIFOs, feeds vertical-overlap pixels back in, so rows already fetched are never refetched. The registered window goes to the depthwise MAC array.

## Interface
- DW, 8: pixel width in bits
- KSIZE, 3: kernel width; window columns per lane
- POY, 3: output rows in parallel; number of lanes
- FDEPTH, 32: reuse FIFO depth per lane (maximum feature-map row width); power of two
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush of array, fill count and FIFOs
- cmd_valid  in  1  qualifies cmd
- cmd  in  2  00 LOAD, 01 PAD, 10 REUSE, 11 reserved
- buf_pix  in  POY*DW  buffer pixels; lane p at bits [p*DW +: DW]
- win_data  out  POY*KSIZE*DW  window; tap R[p][k] at bits [(p*KSIZE+k)*DW +: DW]
- win_valid  out  1  window holds KSIZE valid columns
- col_stb  out  1  one-cycle pulse; window advanced and win_valid
- err_ovf  out  1  sticky; FIFO write attempted while full
- err_udf  out  1  sticky; FIFO read attempted while empty
- err_cmd  out  1  sticky; reserved cmd received

## Operation
- Array R[p][k], p in 0..POY-1, k in 0..KSIZE-1. Column 0 is newest. Every accepted cmd does R[p][k] <= R[p][k-1] for k≥1, then loads R[p][0]:
  - LOAD: R[p][0] <= buf_pix[p] for all lanes.
  - PAD: R[p][0] <= 0 for all lanes (right/left zero padding).
  - REUSE: R[p][0] <= head of FIFO p for p<POY-1; R[POY-1][0] <= buf_pix[POY-1].
  - 11: no array change, no FIFO activity, err_cmd <= 1.
- FIFO writes: on LOAD and REUSE, the pixel entering lane p+1 is pushed into FIFO p, for p in 0..POY-2. PAD pixels are not pushed.
- FIFO reads: on REUSE, every FIFO p<POY-1 pops its head. FIFOs are show-ahead, so the head is valid combinationally in the same cycle.
- A simultaneous pop and push on the same FIFO is legal in any state. When full, the push is accepted because the pop frees a slot.
- fill_cnt saturates at KSIZE:
  - increments on every accepted LOAD, PAD or REUSE;
  - win_valid = (fill_cnt == KSIZE).
- Overflow: a push to a full FIFO without a pop is dropped and sets err_ovf. The array is still updated.
- Underflow: a pop from an empty FIFO yields pixel 0 for that lane and sets err_udf. The pointers do not move.
- clear: array, fill_cnt and FIFO pointers go to 0. Error flags are held.
- clear together with cmd_valid in the same cycle: clear wins and the cmd is dropped.
- Reset (rst_n=0): win_data=0, win_valid=0, col_stb=0, all err_* = 0, fill_cnt=0, all FIFOs empty.

## Timing
- Cmd sampled at edge t; R, fill_cnt, FIFO state, win_data and win_valid all update at edge t. They are visible in cycle t+1.
- col_stb is high in cycle t+1 iff a non-reserved cmd was accepted at edge t and the post-update fill_cnt == KSIZE.
- The upstream sequencer may issue a cmd every cycle. There is no backpressure: the array always accepts.
- Error flags rise in the cycle after the offending cmd and clear only on reset.
- buf_pix must be stable in the same cycle as its qualifying cmd_valid. This block adds no alignment delay.

## Structure
- Package dw_pkg:
  - enum typedef dw_cmd_e {CMD_LOAD=2'b00, CMD_PAD=2'b01, CMD_REUSE=2'b10, CMD_RSVD=2'b11}, shared with the upstream sequencer;
  - pixel typedef parameterised by DW.
- Sub-module reuse_fifo:
  - synchronous show-ahead FIFO (DW × FDEPTH) with push, pop, full, empty;
  - pointers are log2(FDEPTH)+1 bits, with the MSB used for wrap detection;
  - instantiated POY-1 times in a generate loop.
- Top level holds the array, fill counter, error flags and command decode.

## Test plan
All scenarios use DW=8, KSIZE=3, POY=3.
- Reset:
  - rst_n low for 2 cycles -> all outputs 0.
  - Issue LOAD during reset -> no change.
- Fill:
  - LOADs with lanes {10,20,30}, {11,21,31}, {12,22,32} -> win_valid=0 after the first two.
  - After the third -> lane0 taps k0..k2 = 12,11,10; lane2 = 32,31,30; win_valid=1 and col_stb pulses once.
- Reuse: after the fill, REUSE with buf_pix lane2=40:
  - lane0 k0=20; lane1 k0=30; lane2 k0=40;
  - FIFO0 head becomes 21.
- Pad and underflow:
  - PAD -> k0 of all lanes = 0, win_valid stays 1, no FIFO push.
  - Then clear and REUSE on empty FIFOs -> lanes 0-1 get 0 and err_udf=1 persists after clear.
- Overflow/wrap:
  - 33 LOADs after clear -> err_ovf=1 and the FIFOs hold the first 32 pushed pixels.
  - Then 32 REUSEs -> pixels return in order, and the pointers wrap cleanly.
- Conflicts:
  - clear together with LOAD in the same cycle -> array = 0 and fill_cnt = 0.
  - cmd=11 -> array unchanged, err_cmd=1.
